// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM Avalon-MM master port between two
// requesters (M0 = dataset loader / pattern writer, M1 = memory_control).
// The granted master's command is passed combinationally to the SDRAM, and a
// small read-ID FIFO routes each readdatavalid back to the master that issued
// the read. Grants change only on command boundaries.
//
// Optional build macro: FIXED_PRIORITY_M1_EN
//   undefined -> round-robin tie-break, contested grants yielded after
//                HOLD_MAX accepted transfers
//   defined   -> M1 wins every tie, M0 yields to M1 after each transfer,
//                M1 never yields on a transfer count
//
// state | meaning
// IDLE  | no owner, command strobes to SDRAM held low
// GNT0  | M0 owns the SDRAM port
// GNT1  | M1 owns the SDRAM port
module sdram_port_arbiter #(
  parameter int W           = 16,
  parameter int ADDR_W      = 25,
  parameter int MAX_PENDING = 4,
  parameter int HOLD_MAX    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [W-1:0]      m0_writedata,
  output logic              m0_waitrequest,
  output logic [W-1:0]      m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [W-1:0]      m1_writedata,
  output logic              m1_waitrequest,
  output logic [W-1:0]      m1_readdata,
  output logic              m1_readdatavalid,
  output logic              s_read,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_address,
  output logic [W-1:0]      s_writedata,
  input  logic              s_waitrequest,
  input  logic [W-1:0]      s_readdata,
  input  logic              s_readdatavalid,
  output logic [1:0]        grant,
  output logic              protocol_error
);

  localparam int PTR_W  = $clog2(MAX_PENDING);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t             state, state_next;
  logic               rr_last, rr_last_next;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [MAX_PENDING-1:0] id_mem;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;

  logic req0, req1;
  logic gnt_read, gnt_write, blocked, accept;
  logic fifo_full, fifo_empty, head_id, push, pop;
  logic hold_done, tie_m1, yield0, yield1;

  assign req0       = m0_read | m0_write;
  assign req1       = m1_read | m1_write;
  assign fifo_full  = (count == CNT_W'(MAX_PENDING));
  assign fifo_empty = (count == '0);
  assign head_id    = id_mem[rd_ptr];
  assign push       = accept & gnt_read;
  assign pop        = s_readdatavalid & ~fifo_empty;
  // The accept that brings the count up to HOLD_MAX is the last one granted.
  assign hold_done  = (hold_cnt >= HOLD_W'(HOLD_MAX - 1));

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

`ifdef FIXED_PRIORITY_M1_EN
  assign tie_m1 = 1'b1;
  assign yield0 = 1'b1;
  assign yield1 = 1'b0;
`else
  assign tie_m1 = ~rr_last;
  assign yield0 = hold_done;
  assign yield1 = hold_done;
`endif

  // State register, round-robin memory and per-grant transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      hold_cnt <= '0;
    end else begin
      state   <= state_next;
      rr_last <= rr_last_next;
      if (state_next != state)
        hold_cnt <= '0;
      else if (accept && hold_cnt != HOLD_W'(HOLD_MAX))
        hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // Read-ID FIFO: one bit per outstanding read naming the issuing master.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_mem         <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= (state == GNT1);
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (s_readdatavalid && fifo_empty)
        protocol_error <= 1'b1;
    end
  end

  // Next-state: grants move only when the owner has no command or it was just accepted.
  always_comb begin
    state_next   = state;
    rr_last_next = rr_last;
    case (state)
      IDLE: begin
        if (req0 && req1)
          state_next = tie_m1 ? GNT1 : GNT0;
        else if (req0)
          state_next = GNT0;
        else if (req1)
          state_next = GNT1;
      end
      GNT0: begin
        if (!req0) begin
          state_next   = IDLE;
          rr_last_next = 1'b0;
        end else if (accept && req1 && yield0) begin
          state_next   = GNT1;
          rr_last_next = 1'b0;
        end
      end
      GNT1: begin
        if (!req1) begin
          state_next   = IDLE;
          rr_last_next = 1'b1;
        end else if (accept && req0 && yield1) begin
          state_next   = GNT0;
          rr_last_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: command mux from the owner, stalls, and read-return routing.
  always_comb begin
    gnt_read    = 1'b0;
    gnt_write   = 1'b0;
    s_address   = '0;
    s_writedata = '0;
    grant       = 2'b00;
    case (state)
      GNT0: begin
        gnt_read    = m0_read;
        gnt_write   = m0_write;
        s_address   = m0_address;
        s_writedata = m0_writedata;
        grant       = 2'b01;
      end
      GNT1: begin
        gnt_read    = m1_read;
        gnt_write   = m1_write;
        s_address   = m1_address;
        s_writedata = m1_writedata;
        grant       = 2'b10;
      end
      default: ;
    endcase
    // A read with no free ID slot is held back; writes never wait on the FIFO.
    blocked          = gnt_read & fifo_full;
    accept           = (gnt_read | gnt_write) & ~s_waitrequest & ~blocked;
    s_read           = gnt_read & ~blocked;
    s_write          = gnt_write & ~blocked;
    m0_waitrequest   = (state == GNT0) ? (s_waitrequest | blocked) : 1'b1;
    m1_waitrequest   = (state == GNT1) ? (s_waitrequest | blocked) : 1'b1;
    m0_readdatavalid = pop & ~head_id;
    m1_readdatavalid = pop & head_id;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter: command-queue master drivers, an SDRAM
// responder with fixed read latency, and a transaction-level reference model
// checked every cycle, plus directed literal expectations per scenario.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam int W = 16, AW = 25, MAXP = 4, HOLDM = 16;
  // Read data appears LAT cycles after the accepting cycle (3 wait cycles between).
  localparam int LAT = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic m0_read, m0_write, m0_waitrequest, m0_readdatavalid;
  logic [AW-1:0] m0_address;
  logic [W-1:0]  m0_writedata, m0_readdata;
  logic m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
  logic [AW-1:0] m1_address;
  logic [W-1:0]  m1_writedata, m1_readdata;
  logic s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [AW-1:0] s_address;
  logic [W-1:0]  s_writedata, s_readdata;
  logic [1:0] grant;
  logic protocol_error;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.W(W), .ADDR_W(AW), .MAX_PENDING(MAXP), .HOLD_MAX(HOLDM)) dut (
    .clk(clk), .rst(rst),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_read(s_read), .s_write(s_write), .s_address(s_address),
    .s_writedata(s_writedata), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .grant(grant), .protocol_error(protocol_error)
  );

  typedef struct { bit idle; bit wr; logic [AW-1:0] addr; logic [W-1:0] data; } cmd_t;
  typedef struct { int due; logic [W-1:0] data; } ret_t;
  typedef struct { int id; logic [W-1:0] data; } pend_t;

  cmd_t q0[$], q1[$];
  ret_t rq[$];
  int pres0, pres1;         // 0 nothing, 1 command, 2 idle gap
  bit a0, a1, rd_acc, inject, stall_en;
  logic [AW-1:0] rd_addr;
  int cyc;
  int checks, errors;

  int route_log[$], acc_log[$];
  logic [W-1:0] m1_data[$];
  int m1_stall_n, s_write_n;

  function automatic cmd_t mk(input bit idle, input bit wr, input int addr, input int data);
    cmd_t c;
    c.idle = idle; c.wr = wr; c.addr = AW'(addr); c.data = W'(data);
    return c;
  endfunction

  function automatic logic [W-1:0] rdata(input logic [AW-1:0] a);
    return a[W-1:0] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Master drivers and SDRAM responder: sample at negedge, drive after posedge.
  initial begin
    m0_read = 0; m0_write = 0; m0_address = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_writedata = '0;
    s_waitrequest = 0; s_readdata = '0; s_readdatavalid = 0;
    pres0 = 0; pres1 = 0; cyc = 0; inject = 0; stall_en = 0;
    forever begin
      @(negedge clk);
      a0 = (m0_read || m0_write) && !m0_waitrequest;
      a1 = (m1_read || m1_write) && !m1_waitrequest;
      rd_acc = s_read && !s_waitrequest;
      rd_addr = s_address;
      @(posedge clk);
      cyc++;
      #1;
      if (rd_acc) rq.push_back('{cyc - 1 + LAT, rdata(rd_addr)});
      s_readdatavalid = inject;
      s_readdata = '0;
      inject = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        s_readdatavalid = 1;
        s_readdata = rq[0].data;
        void'(rq.pop_front());
      end
      s_waitrequest = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
      if ((pres0 == 1 && a0) || pres0 == 2) void'(q0.pop_front());
      if ((pres1 == 1 && a1) || pres1 == 2) void'(q1.pop_front());
      pres0 = 0; m0_read = 0; m0_write = 0;
      if (q0.size() > 0) begin
        if (q0[0].idle) pres0 = 2;
        else begin
          pres0 = 1; m0_read = !q0[0].wr; m0_write = q0[0].wr;
          m0_address = q0[0].addr; m0_writedata = q0[0].data;
        end
      end
      pres1 = 0; m1_read = 0; m1_write = 0;
      if (q1.size() > 0) begin
        if (q1[0].idle) pres1 = 2;
        else begin
          pres1 = 1; m1_read = !q1[0].wr; m1_write = q1[0].wr;
          m1_address = q1[0].addr; m1_writedata = q1[0].data;
        end
      end
    end
  end

  // Reference model: owner, transfers since grant, last yielder, outstanding reads.
  initial begin
    int owner, held, rr, x, e_gnt;
    bit mvalid, perr, perr_n, req0, req1, rx, ro, rd, wr, full, blk, acc, e_w0, e_w1, e_r0, e_r1, yields;
    logic [AW-1:0] ea;
    logic [W-1:0] ed, edata;
    pend_t idq[$];
    mvalid = 0; owner = 0; held = 0; rr = 1; perr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        owner = 0; held = 0; rr = 1; perr = 0; idq.delete(); mvalid = 1;
      end else if (mvalid) begin
        req0 = m0_read || m0_write;
        req1 = m1_read || m1_write;
        rd = 0; wr = 0; ea = '0; ed = '0;
        if (owner == 1) begin rd = m0_read; wr = m0_write; ea = m0_address; ed = m0_writedata; end
        if (owner == 2) begin rd = m1_read; wr = m1_write; ea = m1_address; ed = m1_writedata; end
        full = (idq.size() >= MAXP);
        blk = rd && full;
        acc = (rd || wr) && !s_waitrequest && !blk;
        e_w0 = (owner == 1) ? (s_waitrequest || blk) : 1'b1;
        e_w1 = (owner == 2) ? (s_waitrequest || blk) : 1'b1;
        e_r0 = 0; e_r1 = 0; edata = '0;
        if (s_readdatavalid && idq.size() > 0) begin
          if (idq[0].id == 0) e_r0 = 1; else e_r1 = 1;
          edata = idq[0].data;
        end
        e_gnt = owner;
        chk("grant", grant, e_gnt);
        chk("s_read", s_read, rd && !blk);
        chk("s_write", s_write, wr && !blk);
        if ((rd || wr) && !blk) chk("s_address", s_address, ea);
        if (wr && !blk) chk("s_writedata", s_writedata, ed);
        chk("m0_waitrequest", m0_waitrequest, e_w0);
        chk("m1_waitrequest", m1_waitrequest, e_w1);
        chk("m0_readdatavalid", m0_readdatavalid, e_r0);
        chk("m1_readdatavalid", m1_readdatavalid, e_r1);
        if (e_r0) chk("m0_readdata", m0_readdata, edata);
        if (e_r1) chk("m1_readdata", m1_readdata, edata);
        chk("protocol_error", protocol_error, perr);

        if (m0_readdatavalid) route_log.push_back(0);
        if (m1_readdatavalid) begin route_log.push_back(1); m1_data.push_back(m1_readdata); end
        if ((m0_read || m0_write) && !m0_waitrequest) acc_log.push_back(0);
        if ((m1_read || m1_write) && !m1_waitrequest) acc_log.push_back(1);
        if (grant == 2'b10 && m1_read && m1_waitrequest) m1_stall_n++;
        if (s_write && !s_waitrequest) s_write_n++;

        perr_n = perr;
        if (s_readdatavalid) begin
          if (idq.size() > 0) void'(idq.pop_front());
          else perr_n = 1;
        end
        perr = perr_n;
        if (acc && rd) idq.push_back('{owner - 1, rdata(ea)});

        if (owner == 0) begin
`ifdef FIXED_PRIORITY_M1_EN
          if (req0 && req1) owner = 2;
`else
          if (req0 && req1) owner = (rr == 1) ? 1 : 2;
`endif
          else if (req0) owner = 1;
          else if (req1) owner = 2;
          held = 0;
        end else begin
          x = owner - 1;
          rx = (x == 1) ? req1 : req0;
          ro = (x == 1) ? req0 : req1;
          if (!rx) begin
            owner = 0; rr = x; held = 0;
          end else if (acc) begin
            held++;
`ifdef FIXED_PRIORITY_M1_EN
            yields = (x == 0);
`else
            yields = (held >= HOLDM);
`endif
            if (ro && yields) begin owner = 3 - owner; rr = x; held = 0; end
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1; rst = 1;
    @(posedge clk); @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_s_cmd", {s_read, s_write}, 2'b00);
    chk("rst_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
    chk("rst_perr", protocol_error, 0);
    @(posedge clk); #1; rst = 0;
    route_log.delete(); acc_log.delete(); m1_data.delete();
    m1_stall_n = 0; s_write_n = 0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || rq.size() > 0 || pres0 != 0 || pres1 != 0 || grant != 2'b00)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_in_budget"}, n < budget, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int glog [0:40];
    int exp_route [4];
    int n0;
    checks = 0; errors = 0; m1_stall_n = 0; s_write_n = 0;

    // 64 M0 writes with an idle M1: one request cycle, then a write per cycle.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 64; i++) q0.push_back(mk(0, 1, 'h100 + i, 'hA000 + i));
    @(negedge clk);
    chk("t1_req_cycle_grant", grant, 2'b00);
    chk("t1_req_cycle_wait", m0_waitrequest, 1);
    @(negedge clk);
    chk("t1_grant_next_cycle", grant, 2'b01);
    wait_drain(300, "t1");
    chk("t1_write_pulses", s_write_n, 64);

`ifndef FIXED_PRIORITY_M1_EN
    // Contested streaming from reset: 16 transfers per turn, no gap cycle.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      q0.push_back(mk(0, 1, 'h1000 + i, i));
      q1.push_back(mk(0, 1, 'h2000 + i, 'h8000 + i));
    end
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      glog[k] = int'(grant);
    end
    chk("t2_req_cycle", glog[0], 0);
    chk("t2_first_gnt0", glog[1], 1);
    chk("t2_last_gnt0", glog[16], 1);
    chk("t2_switch_gnt1", glog[17], 2);
    chk("t2_last_gnt1", glog[32], 2);
    chk("t2_back_gnt0", glog[33], 1);
    wait_drain(300, "t2");
`endif

    // Six back-to-back M1 reads: the fifth waits one cycle on a full ID FIFO,
    // including the cycle where a return pops while the FIFO is full.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 6; i++) q1.push_back(mk(0, 0, 'h200 + i, 0));
    wait_drain(200, "t3");
    chk("t3_full_stall_cycles", m1_stall_n, 1);
    chk("t3_m1_returns", m1_data.size(), 6);
    n0 = 0;
    foreach (route_log[i]) if (route_log[i] == 0) n0++;
    chk("t3_m0_returns", n0, 0);
    for (int i = 0; i < 6 && i < m1_data.size(); i++)
      chk($sformatf("t3_m1_data%0d", i), m1_data[i], (16'h200 + 16'(i)) ^ 16'h5A5A);

    // Interleaved reads from both masters keep their return order.
    do_reset();
    @(negedge clk);
    q0.push_back(mk(0, 0, 'h300, 0)); q0.push_back(mk(0, 0, 'h301, 0));
    q1.push_back(mk(0, 0, 'h400, 0)); q1.push_back(mk(0, 0, 'h401, 0));
    wait_drain(200, "t4");
`ifdef FIXED_PRIORITY_M1_EN
    exp_route = '{1, 1, 0, 0};
`else
    exp_route = '{0, 0, 1, 1};
`endif
    chk("t4_route_count", route_log.size(), 4);
    for (int i = 0; i < 4 && i < route_log.size(); i++)
      chk($sformatf("t4_route%0d", i), route_log[i], exp_route[i]);

    // Spurious readdatavalid: dropped, sticky error until reset.
    do_reset();
    @(negedge clk);
    inject = 1;
    @(negedge clk);
    chk("t5_no_rdv", {m0_readdatavalid, m1_readdatavalid}, 2'b00);
    @(negedge clk);
    chk("t5_perr_set", protocol_error, 1);
    for (int i = 0; i < 4; i++) q1.push_back(mk(0, 1, 'h500 + i, i));
    wait_drain(100, "t5");
    chk("t5_perr_sticky", protocol_error, 1);
    chk("t5_route_empty", route_log.size(), 0);

`ifdef FIXED_PRIORITY_M1_EN
    // M1 priority: M0 gets exactly one transfer per two-cycle M1 gap.
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 10; i++) q0.push_back(mk(0, 1, 'h600 + i, i));
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 4; i++) q1.push_back(mk(0, 1, 'h700 + 4 * g + i, i));
      if (g < 2) begin q1.push_back(mk(1, 0, 0, 0)); q1.push_back(mk(1, 0, 0, 0)); end
    end
    wait_drain(300, "t7");
    chk("t7_accept_count", acc_log.size(), 22);
    for (int i = 0; i < 14 && i < acc_log.size(); i++)
      chk($sformatf("t7_owner%0d", i), acc_log[i], (i == 4 || i == 9) ? 0 : 1);
`endif

    // Mixed reads/writes, idle gaps and random SDRAM stalls against the model.
    do_reset();
    stall_en = 1;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      q0.push_back(mk($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 32'h1FFFFFF), $urandom));
      q1.push_back(mk($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 32'h1FFFFFF), $urandom));
    end
    wait_drain(3000, "t6");
    stall_en = 0;
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
